// File: rtl/ddr5_adr_pkg.sv
// Shared constants for the DDR5 ADR sequencer.
// FSM encodings are visible on the debug state port.
package ddr5_adr_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARMED   = 3'd1;
   localparam logic [2:0] S_TRIGGER = 3'd2;
   localparam logic [2:0] S_WAIT    = 3'd3;
   localparam logic [2:0] S_HOLD    = 3'd4;

   localparam int DEF_T_DEBOUNCE = 4;
   localparam int DEF_T_TIMEOUT  = 50000;

endpackage

// File: rtl/ddr5_adr_sync.sv
// Two-flop synchronizer with a selectable reset value.
// Reset is synchronous and active-low.
module ddr5_adr_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic iClk,
   input  logic iRst_n,
   input  logic iD,
   output logic oQ
);

   logic meta;

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         meta <= RST_VAL;
         oQ   <= RST_VAL;
      end else begin
         meta <= iD;
         oQ   <= meta;
      end
   end

endmodule

// File: rtl/ddr5_adr_ctrl.sv
// ADR sequencer: AC-fail debounce, PCH trigger, completion wait,
// then per-MC ADR hold for DIMMs whose DRAM rail was good.
module ddr5_adr_ctrl
   import ddr5_adr_pkg::*;
#(
   parameter int MC_SIZE    = 4,
   parameter int T_DEBOUNCE = DEF_T_DEBOUNCE,
   parameter int T_TIMEOUT  = DEF_T_TIMEOUT
) (
   input  logic               iClk,
   input  logic               iRst_n,
   input  logic               iADR_EN,
   input  logic               iPWRGD_PS_PWROK,
   input  logic               iFM_AC_FAIL_N,
   input  logic               iFM_ADR_COMPLETE,
   input  logic [MC_SIZE-1:0] iPWRGD_DRAMPWRGD_OK,
   output logic               oFM_ADR_TRIGGER_N,
   output logic [MC_SIZE-1:0] oADR_LOGIC,
   output logic               oADR_TIMEOUT,
   output logic [2:0]         oADR_STATE
);

   localparam int DW = $clog2(T_DEBOUNCE) + 1;
   localparam int TW = $clog2(T_TIMEOUT) + 1;
   localparam logic [DW-1:0] DB_LIM = DW'(T_DEBOUNCE - 1);
   localparam logic [TW-1:0] TO_LIM = TW'(T_TIMEOUT - 1);

   logic               acNs;
   logic               cmplS;
   logic [2:0]         state;
   logic [2:0]         nxt;
   logic               toHit;
   logic [DW-1:0]      dbCnt;
   logic [TW-1:0]      toCnt;
   logic [MC_SIZE-1:0] mask;
   logic               trigNQ;
   logic [MC_SIZE-1:0] logicQ;
   logic               timeoutQ;

   ddr5_adr_sync #(.RST_VAL(1'b1)) uAcSync (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iD     (iFM_AC_FAIL_N),
      .oQ     (acNs)
   );

   ddr5_adr_sync #(.RST_VAL(1'b0)) uCmplSync (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iD     (iFM_ADR_COMPLETE),
      .oQ     (cmplS)
   );

   // Trigger wins over a coincident enable/PWROK drop in ARMED.
   always_comb begin
      nxt   = state;
      toHit = 1'b0;
      unique case (state)
         S_IDLE:
            if (iADR_EN && iPWRGD_PS_PWROK) nxt = S_ARMED;
         S_ARMED:
            if (!acNs && dbCnt == DB_LIM) nxt = S_TRIGGER;
            else if (!iADR_EN || !iPWRGD_PS_PWROK) nxt = S_IDLE;
         S_TRIGGER:
            nxt = S_WAIT;
         S_WAIT:
            if (cmplS) nxt = S_HOLD;
            else if (toCnt == TO_LIM) begin
               nxt   = S_HOLD;
               toHit = 1'b1;
            end
         S_HOLD:
            nxt = S_HOLD;
         default:
            nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state    <= S_IDLE;
         dbCnt    <= '0;
         toCnt    <= '0;
         mask     <= '0;
         timeoutQ <= 1'b0;
         trigNQ   <= 1'b1;
         logicQ   <= '0;
      end else begin
         state <= nxt;
         if (state == S_ARMED && nxt == S_ARMED && !acNs)
            dbCnt <= (dbCnt == DB_LIM) ? dbCnt : dbCnt + DW'(1);
         else
            dbCnt <= '0;
         if (state == S_WAIT && nxt == S_WAIT)
            toCnt <= (toCnt == TO_LIM) ? toCnt : toCnt + TW'(1);
         else
            toCnt <= '0;
         if (state == S_TRIGGER) mask <= iPWRGD_DRAMPWRGD_OK;
         if (toHit) timeoutQ <= 1'b1;
         trigNQ <= !(nxt == S_TRIGGER || nxt == S_WAIT || nxt == S_HOLD);
         logicQ <= (nxt == S_HOLD) ? mask : '0;
      end
   end

   assign oFM_ADR_TRIGGER_N = trigNQ;
   assign oADR_LOGIC        = logicQ;
   assign oADR_TIMEOUT      = timeoutQ;
   assign oADR_STATE        = state;

endmodule

// File: tb/tb_ddr5_adr_ctrl.sv
// Directed + randomized bench for ddr5_adr_ctrl with an event-time
// reference model derived from the sequencer's timing rules.
module tb_ddr5_adr_ctrl;

   localparam int TD = 4;
   localparam int TT = 16;
   localparam int MC = 4;

   logic          clk = 1'b0;
   logic          iRst_n = 1'b0;
   logic          adrEn = 1'b0;
   logic          pwrOk = 1'b0;
   logic          acN = 1'b1;
   logic          cmpl = 1'b0;
   logic [MC-1:0] dram = '0;
   logic          trigN;
   logic [MC-1:0] adrLogic;
   logic          adrTo;
   logic [2:0]    adrState;

   int cyc = 0;
   int nAssert = 0;
   int nFail = 0;

   ddr5_adr_ctrl #(
      .MC_SIZE    (MC),
      .T_DEBOUNCE (TD),
      .T_TIMEOUT  (TT)
   ) dut (
      .iClk                (clk),
      .iRst_n              (iRst_n),
      .iADR_EN             (adrEn),
      .iPWRGD_PS_PWROK     (pwrOk),
      .iFM_AC_FAIL_N       (acN),
      .iFM_ADR_COMPLETE    (cmpl),
      .iPWRGD_DRAMPWRGD_OK (dram),
      .oFM_ADR_TRIGGER_N   (trigN),
      .oADR_LOGIC          (adrLogic),
      .oADR_TIMEOUT        (adrTo),
      .oADR_STATE          (adrState)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkAll(input string tag, input logic [2:0] st,
                         input logic tn, input logic [MC-1:0] lg,
                         input logic to);
      chk({tag, "/state"}, 32'(adrState), 32'(st));
      chk({tag, "/trigN"}, 32'(trigN), 32'(tn));
      chk({tag, "/logic"}, 32'(adrLogic), 32'(lg));
      chk({tag, "/timeout"}, 32'(adrTo), 32'(to));
   endtask

   task automatic doReset();
      iRst_n = 1'b0;
      adrEn = 1'b0;
      pwrOk = 1'b0;
      acN = 1'b1;
      cmpl = 1'b0;
      tick();
      tick();
      chkAll("reset", 3'd0, 1'b1, '0, 1'b0);
      iRst_n = 1'b1;
   endtask

   // cmplDelay < 0: no completion ever; otherwise the first edge
   // sampling COMPLETE is cmplDelay edges after the trigger edge.
   task automatic runAdr(input string name, input logic [MC-1:0] mask,
                         input int cmplDelay);
      int e1, trigEdge, waitEntry, cmplSample, holdEdge, n, c;
      bit toFlag;
      logic [2:0] st;
      doReset();
      adrEn = 1'b1;
      pwrOk = 1'b1;
      dram = ~mask;
      tick();
      tick();
      chkAll({name, "/armed"}, 3'd1, 1'b1, '0, 1'b0);
      acN = 1'b0;
      e1 = cyc + 1;
      trigEdge = e1 + TD + 1;
      waitEntry = trigEdge + 1;
      if (cmplDelay >= 0) begin
         cmplSample = trigEdge + cmplDelay;
         holdEdge = (cmplSample + 2 < waitEntry + TT) ?
                    cmplSample + 2 : waitEntry + TT;
         toFlag = (cmplSample + 2 > waitEntry + TT);
      end else begin
         cmplSample = -1;
         holdEdge = waitEntry + TT;
         toFlag = 1'b1;
      end
      for (int k = 0; k < TD + TT + 8; k++) begin
         n = cyc + 1;
         if (n <= trigEdge) dram = ~mask;
         else if (n == trigEdge + 1) dram = mask;
         else dram = MC'($urandom);
         cmpl = (cmplSample >= 0 && n >= cmplSample);
         if (n > holdEdge + 1) begin
            adrEn = 1'b0;
            pwrOk = 1'b0;
            acN = 1'b1;
         end
         tick();
         c = cyc;
         if (c < trigEdge) st = 3'd1;
         else if (c == trigEdge) st = 3'd2;
         else if (c < holdEdge) st = 3'd3;
         else st = 3'd4;
         chkAll(name, st, (c >= trigEdge) ? 1'b0 : 1'b1,
                (c >= holdEdge) ? mask : '0,
                (c >= holdEdge) ? toFlag : 1'b0);
      end
   endtask

   initial begin
      int glen;
      logic [MC-1:0] m;

      runAdr("nominal", 4'b1011, 5);

      doReset();
      adrEn = 1'b1;
      pwrOk = 1'b1;
      tick();
      tick();
      for (int g = 0; g < 2; g++) begin
         glen = (g == 0) ? 3 : int'($urandom_range(1, TD - 1));
         acN = 1'b0;
         repeat (glen) tick();
         acN = 1'b1;
         for (int k = 0; k < 8; k++) begin
            tick();
            chk("glitch/trigN", 32'(trigN), 32'd1);
            chk("glitch/state", 32'(adrState), 32'd1);
         end
      end

      runAdr("timeout", MC'($urandom), -1);

      doReset();
      acN = 1'b0;
      pwrOk = 1'b1;
      for (int k = 0; k < 100; k++) begin
         tick();
         chkAll("disabled", 3'd0, 1'b1, '0, 1'b0);
      end
      acN = 1'b1;
      adrEn = 1'b1;
      tick();
      tick();
      chk("armed/state", 32'(adrState), 32'd1);
      adrEn = 1'b0;
      tick();
      chk("enDrop/state", 32'(adrState), 32'd0);
      adrEn = 1'b1;
      tick();
      chk("rearm/state", 32'(adrState), 32'd1);
      pwrOk = 1'b0;
      tick();
      chk("pwrokDrop/state", 32'(adrState), 32'd0);

      for (int r = 0; r < 4; r++) begin
         m = MC'($urandom);
         runAdr("random", m, int'($urandom_range(0, TT + 3)));
      end

      runAdr("simul", MC'($urandom), TT - 1);
      iRst_n = 1'b0;
      tick();
      chkAll("holdReset", 3'd0, 1'b1, '0, 1'b0);
      iRst_n = 1'b1;

      runAdr("lateCmpl", 4'b0110, TT);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nAssert, nFail);
      $finish;
   end

endmodule

// File: doc/ddr5_adr_ctrl.md
# ddr5_adr_ctrl

Per-platform ADR (Asynchronous DRAM Refresh) sequencer in the core CPLD. It takes the PSU AC-fail early warning and triggers ADR at the PCH, then waits for ADR completion or timeout. Afterwards it drives the per-MC ADR control level into the DDR5 power-good/fail logic, so DIMMs whose DRAM rail was good are held in the protected state. It is the initiator side of the ADR control inputs consumed by the DDR5 pwrgd logic.

## Interface

Parameters:
- MC_SIZE, 4, number of CPU memory controllers
- T_DEBOUNCE, 4, consecutive synchronized-low cycles of AC-fail required to trigger (≥1)
- T_TIMEOUT, 16'd50000, cycles to wait for ADR complete before forcing HOLD (≥1)

Ports:
- iClk  in  1  system clock
- iRst_n  in  1  reset; synchronous, active-low
- iADR_EN  in  1  ADR feature enable (BIOS strap/register); level, same clock domain
- iPWRGD_PS_PWROK  in  1  PSU PWROK; same clock domain
- iFM_AC_FAIL_N  in  1  PSU AC-loss early warning, async, active-low
- iFM_ADR_COMPLETE  in  1  ADR complete from PCH, async, active-high
- iPWRGD_DRAMPWRGD_OK  in  MC_SIZE  per-MC DRAM power OK from pwrgd logic
- oFM_ADR_TRIGGER_N  out  1  ADR trigger to PCH, active-low level
- oADR_LOGIC  out  MC_SIZE  per-MC ADR control to pwrgd logic; 1 = ADR in effect
- oADR_TIMEOUT  out  1  sticky: ADR complete not received within T_TIMEOUT
- oADR_STATE  out  3  current FSM encoding, debug

## Operation

- Both async inputs pass through 2-flop synchronizers; all decisions use the synchronized values (ac_n_s, cmpl_s).
- FSM states and encodings: IDLE=0, ARMED=1, TRIGGER=2, WAIT_CMPL=3, HOLD=4.
- IDLE: when iADR_EN=1 and iPWRGD_PS_PWROK=1, go to ARMED.
- ARMED:
  - Debounce counter increments while ac_n_s=0 and clears when ac_n_s=1.
  - When the counter equals T_DEBOUNCE-1 and ac_n_s=0, go to TRIGGER.
  - If iADR_EN=0 or iPWRGD_PS_PWROK=0, go to IDLE and clear the counter. Trigger has priority when it coincides with either condition.
- TRIGGER: latch mask = iPWRGD_DRAMPWRGD_OK. Unconditionally go to WAIT_CMPL on the next cycle.
- WAIT_CMPL:
  - Timeout counter starts at 0.
  - If cmpl_s=1, go to HOLD.
  - Otherwise, when the counter reaches T_TIMEOUT-1, set oADR_TIMEOUT and go to HOLD.
  - If cmpl_s=1 on the same cycle as the limit, take HOLD without setting timeout.
- HOLD: terminal until reset. iADR_EN, PWROK and AC-fail recovery are ignored; the platform power-cycles.
- Outputs are registered and decoded from the next state:
  - oFM_ADR_TRIGGER_N = 0 in TRIGGER, WAIT_CMPL and HOLD.
  - oADR_LOGIC = mask in HOLD, else 0.
- Mask width is MC_SIZE. A bit whose DRAM rail was not good at trigger time stays 0 in HOLD.
- Reset mid-operation returns to IDLE with all outputs at their reset values. This includes clearing oADR_TIMEOUT and the mask.

## Timing

- Reset values:
  - oFM_ADR_TRIGGER_N=1
  - oADR_LOGIC=0
  - oADR_TIMEOUT=0
  - oADR_STATE=0
  - synchronizer flops=1 for AC-fail, 0 for complete
- AC-fail latency: take edge 1 as the first rising edge that samples iFM_AC_FAIL_N=0. Synchronizer output is low after edge 2. oFM_ADR_TRIGGER_N goes low after edge T_DEBOUNCE+2.
- A low glitch shorter than T_DEBOUNCE synchronized cycles never triggers.
- Mask latch: iPWRGD_DRAMPWRGD_OK is sampled at the edge leaving TRIGGER, one cycle after the trigger asserts.
- Complete latency: take edge 1 as the first edge sampling iFM_ADR_COMPLETE=1 in WAIT_CMPL. oADR_LOGIC updates after edge 3.
- Timeout: WAIT_CMPL is entered at edge E. With no complete, oADR_TIMEOUT=1 and oADR_LOGIC=mask after edge E+T_TIMEOUT.
- Counters are sized $clog2(param)+1 and never wrap; they saturate at their limits.

## Structure

- Shared package ddr5_adr_pkg holds:
  - FSM state localparams and their 3-bit encodings
  - default T_DEBOUNCE and T_TIMEOUT values
- One sub-module, ddr5_adr_sync: parameterized-reset 2-flop synchronizer, instantiated for AC-fail and ADR-complete.
- Top level integrates alongside the per-MC DDR5 pwrgd instances. oADR_LOGIC[i] connects to each instance's ADR control input.

## Test plan

Bench parameters: T_DEBOUNCE=4, T_TIMEOUT=16, MC_SIZE=4.

- **Nominal trigger.** Stimulus: ADR_EN=1, PWROK=1, DRAMPWRGD_OK=4'b1011; AC_FAIL_N low and held; COMPLETE high 5 cycles after trigger. Required: trigger low after edge 6; oADR_LOGIC=4'b1011 two cycles after COMPLETE is sampled; oADR_TIMEOUT=0.
- **Glitch rejection.** Stimulus: in ARMED, AC_FAIL_N low for 3 cycles, then high. Required: oFM_ADR_TRIGGER_N stays 1 and oADR_STATE=1.
- **Timeout.** Stimulus: trigger with no COMPLETE. Required: oADR_TIMEOUT=1 and oADR_LOGIC=mask exactly 16 cycles after WAIT_CMPL entry; both held afterwards.
- **Disabled.** Stimulus: ADR_EN=0, AC_FAIL_N low for 100 cycles. Required: state stays IDLE and all outputs stay at reset values. Separately, ADR_EN dropping in ARMED returns the FSM to IDLE.
- **Simultaneous events and reset.** Stimulus: COMPLETE arrives on the timeout-limit cycle. Required: HOLD with oADR_TIMEOUT=0. Then assert iRst_n=0 for 1 cycle in HOLD. Required: all outputs return to reset values at the next edge.
